fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue for the single-cycle CPU datapath. Sits between the program counter / instruction memory and the control unit. Holds its own fetch PC, reads the combinational instruction memory every cycle, and buffers {pc, instruction} pairs in a small FIFO. The decode side drains the FIFO with a valid/ready handshake, and a redirect input handles jumps and branches.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `imem_addr`  out  ADDR_W  byte address to instruction memory; equals fetch PC register.
- `imem_rdata`  in  DATA_W  instruction at `imem_addr`, combinational, same cycle.
- `redirect_valid`  in  1  jump/branch taken; flush and reload PC.
- `redirect_addr`  in  ADDR_W  new fetch PC.
- `out_valid`  out  1  `out_inst`/`out_pc` hold a valid instruction.
- `out_ready`  in  1  decode accepts this cycle.
- `out_inst`  out  DATA_W  instruction at FIFO head.
- `out_pc`  out  ADDR_W  address of `out_inst`.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- State: `fetch_pc`, FIFO storage (DEPTH × (ADDR_W+DATA_W)), read pointer, write pointer, count.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is separate, range 0..DEPTH.
- `pop` = `out_valid & out_ready`.
- `push` = `!redirect_valid & (count < DEPTH | pop)`.
  - Pushing while full is allowed when a pop happens in the same cycle.
- On push:
  - Entry {`fetch_pc`, `imem_rdata`} is written at the write pointer.
  - `fetch_pc` ← `fetch_pc` + 4, modulo 2^ADDR_W; wraps from all-ones-minus-3 to 0.
- No push while full without a pop: `fetch_pc` holds and memory is re-read next cycle.
- Redirect has highest priority:
  - Count, read pointer and write pointer go to 0.
  - `fetch_pc` ← `redirect_addr`.
  - No push occurs that cycle.
  - A pop in the redirect cycle still completes; decode has consumed that instruction.
- Count update when no redirect: count + push − pop.
- `out_valid` = (count != 0). `out_inst`/`out_pc` come from the head entry.
- `level` = count.

## Timing
- Reset (`rst`=0 at a rising edge):
  - `fetch_pc` = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - Count = 0, pointers = 0, `out_valid` = 0, `level` = 0.
  - `out_inst`/`out_pc` = 0.
- Reset mid-operation discards all entries. Redirect is ignored while `rst`=0.
- Latency without bypass: an instruction fetched in cycle N is presented with `out_valid`=1 in cycle N+1.
  - First `out_valid` is the first cycle after reset release.
- After a redirect in cycle N:
  - `imem_addr` = `redirect_addr` in cycle N+1.
  - `out_valid`=0 in cycle N+1; target instruction visible in cycle N+2 (non-bypass).
- Steady state with `out_ready`=1 sustains one instruction per cycle.
- `out_ready`=0 for DEPTH cycles fills the queue:
  - `level`=DEPTH.
  - `imem_addr` freezes at last pushed PC + 4.
- All outputs are registered or derived from registers, except in bypass mode.

## Configuration
- `FETCHQ_BYPASS_EN` defined:
  - When count==0 and `redirect_valid`=0, `out_valid`=1 combinationally.
  - `out_inst`=`imem_rdata`, `out_pc`=`fetch_pc`.
  - If `out_ready`=1 that cycle, the instruction is not written to the FIFO; `fetch_pc` still advances by 4.
  - If `out_ready`=0, it is pushed normally.
  - Latency becomes 0 cycles; after a redirect the target is visible in cycle N+1.
- Not defined: no combinational path from `imem_rdata` to outputs; latency is 1 cycle as above.

## Test plan
- Reset, `out_ready`=1, memory returns word = addr:
  - Non-bypass: `out_pc` sequence 0,4,8,12… starting in cycle 1, one per cycle.
  - Bypass: same sequence starting in cycle 0.
- `out_ready`=0 for 6 cycles, DEPTH=4:
  - `level` saturates at 4 and `imem_addr` holds at 16.
  - Then `out_ready`=1: `out_pc` 0,4,8,12,16 with no gaps or duplicates.
- Full queue with `out_ready`=1 on every cycle: push and pop in the same cycle keep `level`=4 and `imem_addr` advances by 4 each cycle.
- Redirect to 0x100 with `level`=3 and `out_ready`=1:
  - Head is consumed that cycle.
  - Next cycle `level`=0 and `imem_addr`=0x100.
  - First `out_pc` after that is 0x100; no stale pre-redirect PCs appear.
- Redirect to 0xFFFF_FFF8, run 3 fetches: `out_pc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert `rst`=0 for one edge with `level`=2: `out_valid`=0, `level`=0, `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the PC / instruction memory and
// decode. Owns the fetch PC, reads a combinational instruction memory every
// cycle and buffers {pc, instruction} pairs in a DEPTH-entry FIFO. Decode
// drains it with valid/ready. A redirect flushes the FIFO and reloads the PC.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   imem_addr      byte address to instruction memory (the fetch PC register)
//   imem_rdata     instruction at imem_addr, same cycle
//   redirect_valid taken jump/branch: flush queue, load redirect_addr
//   redirect_addr  new fetch PC
//   out_valid      out_inst/out_pc hold a valid instruction
//   out_ready      decode accepts this cycle
//   out_inst       instruction at queue head
//   out_pc         address of out_inst
//   level          current occupancy, 0..DEPTH
//
// Build option: define FETCHQ_BYPASS_EN to present the memory word directly
// when the queue is empty (zero-latency fetch). Undefined, every output comes
// from registers and fetch-to-decode latency is one cycle.

module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  entry_t head;
  logic   pop, fifo_pop, fifo_push, advance, byp_consume;

  assign head      = mem[rd_ptr];
  assign imem_addr = fetch_pc;
  assign level     = count;

`ifdef FETCHQ_BYPASS_EN
  // Empty queue: present the word being fetched right now. If decode takes it
  // this cycle it never enters the FIFO.
  logic byp;
  assign byp         = (count == '0) & ~redirect_valid;
  assign out_valid   = (count != '0) | byp;
  assign out_inst    = byp ? imem_rdata : head.inst;
  assign out_pc      = byp ? fetch_pc   : head.pc;
  assign byp_consume = byp & out_ready;
`else
  assign out_valid   = (count != '0);
  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign byp_consume = 1'b0;
`endif

  assign pop       = out_valid & out_ready;
  // Only a handshake on a real FIFO entry frees a slot.
  assign fifo_pop  = pop & (count != '0);
  // The PC advances whenever the fetched word is taken, either into the FIFO
  // or straight through the bypass. Full + pop still takes the slot being freed.
  assign advance   = ~redirect_valid & ((count != FULL) | pop);
  assign fifo_push = advance & ~byp_consume;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (redirect_valid) begin
      // A same-cycle pop has already been consumed by decode; nothing to undo.
      fetch_pc <= redirect_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (advance) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (fifo_push) begin
        mem[wr_ptr] <= '{pc: fetch_pc, inst: imem_rdata};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] SALT  = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic [2:0]    level;

  always #5 clk = ~clk;

  // Memory model: word differs from its address so pc/inst swaps show up.
  assign imem_rdata = imem_addr ^ SALT;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .level(level)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any handshake at the negedge, then step past the edge.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_extra: observed pc %0h expected no output", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_inst", out_inst, e ^ SALT);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drained(input string tag);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);

    // Streaming: one instruction per cycle starting the cycle after release.
    rst = 1'b1; out_ready = 1'b1; #1;
    chk("stream_first_invalid", out_valid, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", out_valid, 1);
      cyc();
    end
    drained("stream_drained");

    // Fill with out_ready low, then drain while full pushes keep level at DEPTH.
    do_reset();
    repeat (6) cyc();
    chk("full_level", level, 4);
    chk("full_addr", imem_addr, 32'd16);
    chk("full_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("steady_level", level, 4);
      chk("steady_addr", imem_addr, 32'(16 + 4 * i));
      cyc();
    end
    drained("full_drained");

    // Redirect with level 3 while decode takes the head.
    do_reset();
    repeat (3) cyc();
    chk("pre_redir_level", level, 3);
    chk("pre_redir_addr", imem_addr, 32'd12);
    exp_q.push_back(32'h0);
    redirect_valid = 1'b1; redirect_addr = 32'h100; out_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_level", level, 0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", out_valid, 0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    repeat (4) cyc();
    drained("redir_drained");

    // Address wrap at the top of the space.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    repeat (4) cyc();
    drained("wrap_drained");

    // Reset mid-operation with level 2; redirect during reset is ignored.
    do_reset();
    repeat (2) cyc();
    chk("pre_rst_level", level, 2);
    rst = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h500;
    @(posedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_addr", imem_addr, RPC);
    chk("mid_rst_pc", out_pc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
